// File: rtl/cache_miss_ctrl.sv
// Miss controller behind the direct-mapped L1: buffers write-through traffic,
// drains it to memory, and services read misses with a one-cycle cache fill.
module cache_miss_ctrl #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              stall,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_FILL  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   buf_addr_r [WB_DEPTH];
    logic [DATA_W-1:0]   buf_data_r [WB_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0]    count_r, count_s;
    logic                wr_ready_r;
    logic [ADDR_W-1:0]   miss_addr_r, miss_addr_s;
    logic                mem_req_r, mem_req_s, mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                fill_valid_r, fill_valid_s;
    logic [ADDR_W-1:0]   fill_addr_r, fill_addr_s;
    logic [DATA_W-1:0]   fill_data_r, fill_data_s;
    logic                push_s, pop_s, ack_s, buf_empty_s;

    // An ack only counts against a live request; a write ack retires the head entry.
    assign push_s      = wr_valid && wr_ready_r;
    assign ack_s       = mem_req_r && mem_ack;
    assign pop_s       = ack_s && mem_we_r;
    assign buf_empty_s = (count_r == CNT_W'(0));

    assign wr_ready   = wr_ready_r;
    assign stall      = miss_valid || (state_r != ST_IDLE);
    assign fill_valid = fill_valid_r;
    assign fill_addr  = fill_addr_r;
    assign fill_data  = fill_data_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

    // Buffer bookkeeping: pointers, occupancy and the next-cycle accept flag.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // Next-state and memory/fill request generation.
    always_comb begin
        state_s      = state_r;
        miss_addr_s  = miss_addr_r;
        mem_req_s    = mem_req_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        fill_valid_s = 1'b0;
        fill_addr_s  = fill_addr_r;
        fill_data_s  = fill_data_r;
        // Dropping req on every ack guarantees the mandatory idle cycle.
        if (ack_s) begin
            mem_req_s = 1'b0;
        end else begin
            mem_req_s = mem_req_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (miss_valid) begin
                    miss_addr_s = miss_addr;
                    if (!buf_empty_s || mem_req_r || push_s) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s    = ST_READ;
                        mem_req_s  = 1'b1;
                        mem_we_s   = 1'b0;
                        mem_addr_s = miss_addr;
                    end
                end else if (!buf_empty_s && !mem_req_r) begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = buf_addr_r[rd_ptr_r];
                    mem_wdata_s = buf_data_r[rd_ptr_r];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mem_req_r) begin
                    state_s = ST_DRAIN;
                end else if (!buf_empty_s) begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = buf_addr_r[rd_ptr_r];
                    mem_wdata_s = buf_data_r[rd_ptr_r];
                end else if (push_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s    = ST_READ;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = miss_addr_r;
                end
            end
            ST_READ: begin
                if (ack_s) begin
                    state_s      = ST_FILL;
                    fill_valid_s = 1'b1;
                    fill_addr_s  = miss_addr_r;
                    fill_data_s  = mem_rdata;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            wr_ready_r   <= 1'b1;
            miss_addr_r  <= ADDR_W'(0);
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= ADDR_W'(0);
            mem_wdata_r  <= DATA_W'(0);
            fill_valid_r <= 1'b0;
            fill_addr_r  <= ADDR_W'(0);
            fill_data_r  <= DATA_W'(0);
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            wr_ready_r   <= (count_s != CNT_W'(WB_DEPTH));
            miss_addr_r  <= miss_addr_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            fill_valid_r <= fill_valid_s;
            fill_addr_r  <= fill_addr_s;
            fill_data_r  <= fill_data_s;
        end
    end

    // Write-buffer storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                buf_addr_r[i] <= ADDR_W'(0);
                buf_data_r[i] <= DATA_W'(0);
            end
        end else if (push_s) begin
            buf_addr_r[wr_ptr_r] <= wr_addr;
            buf_data_r[wr_ptr_r] <= wr_data;
        end else begin
            buf_addr_r[wr_ptr_r] <= buf_addr_r[wr_ptr_r];
            buf_data_r[wr_ptr_r] <= buf_data_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: expected memory operations and fills
// are queued as stimulus is driven and matched when the DUT produces them.
module tb_cache_miss_ctrl;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [31:0] data;
    } mem_op_t;

    typedef struct {
        logic [16:0] addr;
        logic [31:0] data;
    } fill_t;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic [16:0] miss_addr;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        stall;
    logic        fill_valid;
    logic [16:0] fill_addr;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_op_t exp_mem_q[$];
    fill_t   exp_fill_q[$];

    int          n_checks;
    int          n_errors;
    int          mem_lat;
    logic        mem_hold;
    logic        ack_force;
    logic [31:0] rd_val;
    int          acks;
    int          fills_seen;
    int          stall_cnt;

    cache_miss_ctrl #(.ADDR_W(17), .DATA_W(32), .WB_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .stall      (stall),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory model: acks after mem_lat request cycles and checks each op in order.
    initial begin
        mem_op_t e;
        int      req_cycles;
        req_cycles = 0;
        acks       = 0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack   = ack_force;
            mem_rdata = 32'd0;
            if (!mem_req) begin
                req_cycles = 0;
            end else if (!mem_hold && !rst) begin
                req_cycles++;
                if (req_cycles >= mem_lat) begin
                    mem_ack    = 1'b1;
                    mem_rdata  = rd_val;
                    req_cycles = 0;
                    acks++;
                    check_eq("mem_op_expected", 64'(exp_mem_q.size() > 0), 64'd1);
                    if (exp_mem_q.size() > 0) begin
                        e = exp_mem_q.pop_front();
                        check_eq("mem_we", 64'(mem_we), 64'(e.we));
                        check_eq("mem_addr", 64'(mem_addr), 64'(e.addr));
                        if (e.we) check_eq("mem_wdata", 64'(mem_wdata), 64'(e.data));
                    end
                end
            end
        end
    end

    // Fill and stall monitor.
    initial begin
        fill_t f;
        fills_seen = 0;
        stall_cnt  = 0;
        forever begin
            @(negedge clk);
            if (stall === 1'b1) stall_cnt++;
            if (fill_valid === 1'b1) begin
                fills_seen++;
                check_eq("fill_expected", 64'(exp_fill_q.size() > 0), 64'd1);
                check_eq("mem_ops_before_fill", 64'(exp_mem_q.size()), 64'd0);
                if (exp_fill_q.size() > 0) begin
                    f = exp_fill_q.pop_front();
                    check_eq("fill_addr", 64'(fill_addr), 64'(f.addr));
                    check_eq("fill_data", 64'(fill_data), 64'(f.data));
                end
            end
        end
    end

    task automatic do_write(input logic [16:0] a, input logic [31:0] d, input logic exp_ready);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        check_eq("wr_ready", 64'(wr_ready), 64'(exp_ready));
        if (exp_ready) exp_mem_q.push_back('{1'b1, a, d});
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_miss(input logic [16:0] a, input logic [31:0] rdata);
        rd_val = rdata;
        exp_mem_q.push_back('{1'b0, a, 32'd0});
        exp_fill_q.push_back('{a, rdata});
        miss_valid = 1'b1;
        miss_addr  = a;
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic wait_fill(input int max_cycles);
        int start;
        start = fills_seen;
        for (int i = 0; i < max_cycles; i++) begin
            if (fills_seen > start) break;
            @(posedge clk); #1;
        end
        check_eq("fill_timeout", 64'(fills_seen > start), 64'd1);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_mem_q.size() == 0 && !mem_req) break;
            @(posedge clk); #1;
        end
        check_eq("drain_timeout", 64'(exp_mem_q.size() == 0 && !mem_req), 64'd1);
    endtask

    initial begin
        int s0;
        int a0;
        n_checks   = 0;
        n_errors   = 0;
        mem_lat    = 1;
        mem_hold   = 1'b0;
        rd_val     = 32'd0;
        miss_valid = 1'b0;
        miss_addr  = 17'd0;
        // Reset with ack and a write request pending: nothing may be recorded.
        rst       = 1'b1;
        ack_force = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 17'd5;
        wr_data   = 32'd99;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_fill_valid", 64'(fill_valid), 64'd0);
        check_eq("rst_fill_addr", 64'(fill_addr), 64'd0);
        check_eq("rst_fill_data", 64'(fill_data), 64'd0);
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
        check_eq("rst_stall", 64'(stall), 64'd0);
        rst       = 1'b0;
        ack_force = 1'b0;
        wr_valid  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("no_push_in_reset", 64'(mem_req), 64'd0);

        // Clean miss, ack latency 3: stall spans 1 + 3 + 1 cycles.
        mem_lat = 3;
        s0 = stall_cnt;
        do_miss(17'd3, 32'd432);
        wait_fill(20);
        repeat (2) @(posedge clk);
        #1;
        check_eq("clean_miss_stall_cycles", 64'(stall_cnt - s0), 64'd5);
        check_eq("clean_miss_stall_low", 64'(stall), 64'd0);

        // Writes ahead of a miss reach memory before its read.
        mem_lat = 2;
        do_write(17'd23, 32'd870, 1'b1);
        do_write(17'd51, 32'd45687, 1'b1);
        do_miss(17'd51, 32'h1234_5678);
        wait_fill(40);
        wait_drain(20);

        // Full buffer: the fifth push is dropped, one ack reopens it.
        mem_lat  = 1;
        mem_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_write(17'(100 + i), 32'(1000 + i), (i < 4) ? 1'b1 : 1'b0);
        end
        check_eq("full_wr_ready", 64'(wr_ready), 64'd0);
        mem_hold = 1'b0;
        a0 = acks;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (acks > a0) break;
        end
        #1;
        check_eq("first_ack_seen", 64'(acks > a0), 64'd1);
        check_eq("wr_ready_after_pop", 64'(wr_ready), 64'd1);
        wait_drain(40);

        // Push and pop on the same edge keep the occupancy at two.
        mem_hold = 1'b1;
        do_write(17'd200, 32'd2000, 1'b1);
        do_write(17'd201, 32'd2001, 1'b1);
        @(posedge clk); #1;
        mem_hold = 1'b0;
        do_write(17'd202, 32'd2002, 1'b1);
        check_eq("push_pop_count", 64'(dut.count_r), 64'd2);
        wait_drain(40);

        // Reset while the read is outstanding abandons it.
        mem_hold   = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 17'd7;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("read_req_before_rst", 64'(mem_req), 64'd1);
        check_eq("read_we_before_rst", 64'(mem_we), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("mid_rst_stall", 64'(stall), 64'd0);
        check_eq("mid_rst_fill_valid", 64'(fill_valid), 64'd0);
        mem_hold = 1'b0;
        mem_lat  = 2;
        repeat (2) @(posedge clk);
        #1;
        do_miss(17'b11100000000110011, 32'hDEAD_BEEF);
        wait_fill(20);
        wait_drain(20);

        repeat (3) @(posedge clk);
        #1;
        check_eq("fills_all_seen", 64'(exp_fill_q.size()), 64'd0);
        check_eq("final_stall", 64'(stall), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
